// File: rtl/axi_copy_dma.sv
// -----------------------------------------------------------------------------
// axi_copy_dma
//   Memory-to-memory copy engine. Software programs SRC, DST and LEN (in 32-bit
//   words), then writes CTRL.start. The engine copies the data as alternating
//   AXI4 INCR read and write bursts through a MAX_BURST-deep line buffer, with
//   only one transaction in flight at any time. Completion and errors are
//   reported in STATUS and on a level interrupt.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   reg_wen/addr/wdata     register write port (0x0 SRC, 0x4 DST, 0x8 LEN,
//                          0xC CTRL: bit0 start, bit1 clear)
//   reg_rdata              combinational readback; 0xC returns {err,done,busy}
//   irq                    level interrupt, done | err
//   m_ar*/m_r*             AXI4 read address / read data channels
//   m_aw*/m_w*/m_b*        AXI4 write address / write data / response channels
// -----------------------------------------------------------------------------
module axi_copy_dma #(
    parameter int ID_W      = 4,
    parameter int MAX_BURST = 16,
    parameter int DMA_ID    = 0
) (
    input  logic            aclk,
    input  logic            aresetn,

    input  logic            reg_wen,
    input  logic [3:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic            irq,

    output logic [ID_W-1:0] m_arid,
    output logic [31:0]     m_araddr,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [1:0]      m_arburst,
    output logic            m_arvalid,
    input  logic            m_arready,

    input  logic [ID_W-1:0] m_rid,
    input  logic [31:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast,
    input  logic            m_rvalid,
    output logic            m_rready,

    output logic [ID_W-1:0] m_awid,
    output logic [31:0]     m_awaddr,
    output logic [7:0]      m_awlen,
    output logic [2:0]      m_awsize,
    output logic [1:0]      m_awburst,
    output logic            m_awvalid,
    input  logic            m_awready,

    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    output logic            m_wlast,
    output logic            m_wvalid,
    input  logic            m_wready,

    input  logic [ID_W-1:0] m_bid,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready
);

    localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int BW = IW + 1;   // holds MAX_BURST itself

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   src_q, src_d, dst_q, dst_d;
    logic [19:0]   len_q, len_d;
    logic          done_q, done_d, err_q, err_d;
    logic [31:0]   cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [19:0]   rem_q, rem_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [BW-1:0] idx_q, idx_d;
    logic          rerr_q, rerr_d;
    logic [31:0]   line_q [MAX_BURST];

    logic          busy;
    logic          ctrl_wr, start_req, clear_req;

    assign busy      = (state_q != S_IDLE);
    assign ctrl_wr   = reg_wen && (reg_addr == 4'hC);
    assign start_req = ctrl_wr && reg_wdata[0];
    assign clear_req = ctrl_wr && reg_wdata[1];

    // Burst length: limited by the words left, the buffer depth and the
    // distance to the next 4 KB page on both the source and destination side.
    logic [12:0]   src_room, dst_room;
    logic [19:0]   beats_w;
    logic [BW-1:0] beats_c;

    always_comb begin
        src_room = 13'h1000 - {1'b0, cur_src_q[11:0]};
        dst_room = 13'h1000 - {1'b0, cur_dst_q[11:0]};
        beats_w  = rem_q;
        if (beats_w > 20'(MAX_BURST))         beats_w = 20'(MAX_BURST);
        if (beats_w > {9'd0, src_room[12:2]}) beats_w = {9'd0, src_room[12:2]};
        if (beats_w > {9'd0, dst_room[12:2]}) beats_w = {9'd0, dst_room[12:2]};
        beats_c = beats_w[BW-1:0];
    end

    // Fixed AXI attributes
    assign m_arid    = ID_W'(DMA_ID);
    assign m_awid    = ID_W'(DMA_ID);
    assign m_arsize  = 3'b010;
    assign m_awsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_awburst = 2'b01;
    assign m_wstrb   = 4'hF;

    // Addresses and lengths come straight from registers that only move in
    // S_B, so they are stable for as long as the valids are held.
    assign m_araddr = cur_src_q;
    assign m_arlen  = 8'(beats_c) - 8'd1;
    assign m_awaddr = cur_dst_q;
    assign m_awlen  = 8'(beats_q) - 8'd1;
    assign m_wdata  = line_q[idx_q[IW-1:0]];
    assign m_wlast  = (idx_q == beats_q - BW'(1));

    assign irq = done_q | err_q;

    always_comb begin
        unique case (reg_addr)
            4'h0:    reg_rdata = src_q;
            4'h4:    reg_rdata = dst_q;
            4'h8:    reg_rdata = {12'd0, len_q};
            4'hC:    reg_rdata = {29'd0, err_q, done_q, busy};
            default: reg_rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        done_d    = done_q;
        err_d     = err_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        beats_d   = beats_q;
        idx_d     = idx_q;
        rerr_d    = rerr_q;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;

        // Clear is evaluated before start so a combined write restarts cleanly.
        if (clear_req) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        if (reg_wen && !busy) begin
            if (reg_addr == 4'h0) src_d = {reg_wdata[31:2], 2'b00};
            if (reg_addr == 4'h4) dst_d = {reg_wdata[31:2], 2'b00};
            if (reg_addr == 4'h8) len_d = reg_wdata[19:0];
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (len_q == 20'd0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_src_d = src_q;
                        cur_dst_d = dst_q;
                        rem_d     = len_q;
                        state_d   = S_AR;
                    end
                end
            end
            S_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    beats_d = beats_c;
                    idx_d   = '0;
                    rerr_d  = 1'b0;
                    state_d = S_R;
                end
            end
            S_R: begin
                // An errored burst is still drained to rlast, then dropped.
                m_rready = 1'b1;
                if (m_rvalid) begin
                    idx_d = idx_q + BW'(1);
                    if (m_rresp != 2'b00) rerr_d = 1'b1;
                    if (m_rlast)
                        state_d = (rerr_q || m_rresp != 2'b00) ? S_ERR : S_AW;
                end
            end
            S_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    idx_d   = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                m_wvalid = 1'b1;
                if (m_wready) begin
                    idx_d = idx_q + BW'(1);
                    if (m_wlast) state_d = S_B;
                end
            end
            S_B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        cur_src_d = cur_src_q + 32'({beats_q, 2'b00});
                        cur_dst_d = cur_dst_q + 32'({beats_q, 2'b00});
                        rem_d     = rem_q - 20'(beats_q);
                        state_d   = (rem_q == 20'(beats_q)) ? S_DONE : S_AR;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            idx_q     <= '0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            rem_q     <= rem_d;
            beats_q   <= beats_d;
            idx_q     <= idx_d;
            rerr_q    <= rerr_d;
        end
    end

    // Line buffer holds data only; no reset needed.
    always_ff @(posedge aclk) begin
        if (state_q == S_R && m_rvalid)
            line_q[idx_q[IW-1:0]] <= m_rdata;
    end

    // IDs are ignored; the room low bits are always zero.
    logic unused_ok;
    assign unused_ok = ^{m_rid, m_bid, src_room[1:0], dst_room[1:0], beats_w[19:BW]};

endmodule

// File: tb/tb_axi_copy_dma.sv
module tb_axi_copy_dma;
    localparam int ID_W = 4;
    localparam int MB   = 16;

    logic aclk = 1'b0, aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic reg_wen = 1'b0; logic [3:0] reg_addr = '0; logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata; logic irq;
    logic [ID_W-1:0] m_arid, m_awid, m_rid = '0, m_bid = '0;
    logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata = '0;
    logic [7:0] m_arlen, m_awlen; logic [2:0] m_arsize, m_awsize;
    logic [1:0] m_arburst, m_awburst, m_rresp = '0, m_bresp = '0;
    logic m_arvalid, m_arready = 1'b0, m_rlast = 1'b0, m_rvalid = 1'b0, m_rready;
    logic m_awvalid, m_awready = 1'b0, m_wlast, m_wvalid, m_wready = 1'b0;
    logic [3:0] m_wstrb; logic m_bvalid = 1'b0, m_bready;

    axi_copy_dma #(.ID_W(ID_W), .MAX_BURST(MB), .DMA_ID(0)) dut (
        .aclk(aclk), .aresetn(aresetn), .reg_wen(reg_wen), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready)
    );

    int total = 0, bad = 0;

    typedef struct { logic [31:0] a; logic [7:0] l; } burst_t;
    burst_t      ar_q[$], aw_q[$];
    logic [31:0] w_q[$];
    logic [31:0] dmem [logic [31:0]];

    typedef struct {
        logic [31:0] src, dst; int len; int stall; int err_beat; int poke;
        logic [31:0] exp_status; int exp_ar; int exp_aw;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] srcw(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int stall_en = 0, err_beat_g = -1;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_gap = 0, b_gap = 0;
    int rd_left = 0, rd_beat = 0, wr_left = 0;
    logic [31:0] rd_addr = '0, wr_addr = '0;
    bit b_pend = 0, open = 0;
    int viol = 0, n_ar = 0, n_aw = 0;
    bit ar_st_p = 0, aw_st_p = 0, w_st_p = 0;
    logic [31:0] ar_a_p, aw_a_p, w_d_p; logic [7:0] ar_l_p, aw_l_p; logic w_l_p;

    function automatic int rnd();
        return stall_en ? int'($urandom_range(0, 5)) : 0;
    endfunction

    always begin
        burst_t e;
        logic [31:0] ew;
        @(negedge aclk);
        if (aresetn) begin
            if (ar_st_p && (!m_arvalid || m_araddr !== ar_a_p || m_arlen !== ar_l_p)) viol++;
            if (aw_st_p && (!m_awvalid || m_awaddr !== aw_a_p || m_awlen !== aw_l_p)) viol++;
            if (w_st_p && (!m_wvalid || m_wdata !== w_d_p || m_wlast !== w_l_p)) viol++;
            if ((m_arvalid || m_awvalid) && open) viol++;
            ar_st_p = m_arvalid && !m_arready; ar_a_p = m_araddr; ar_l_p = m_arlen;
            aw_st_p = m_awvalid && !m_awready; aw_a_p = m_awaddr; aw_l_p = m_awlen;
            w_st_p  = m_wvalid && !m_wready;   w_d_p  = m_wdata;  w_l_p  = m_wlast;

            if (m_arvalid && m_arready) begin
                n_ar++;
                if (ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
                else begin
                    e = ar_q.pop_front();
                    chk("araddr", m_araddr, e.a);
                    chk("arlen", 32'(m_arlen), 32'(e.l));
                end
                chk("ar_attr", {23'd0, m_arsize, m_arburst, m_arid}, {23'd0, 3'b010, 2'b01, 4'h0});
                rd_addr = m_araddr; rd_left = int'(m_arlen) + 1; rd_beat = 0;
                open = 1; ar_cnt = rnd(); r_gap = rnd();
            end
            if (m_rvalid && m_rready) begin
                rd_addr += 4; rd_left--; rd_beat++; r_gap = rnd();
                if (rd_left == 0) open = 0;
            end
            if (m_awvalid && m_awready) begin
                n_aw++;
                if (aw_q.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
                else begin
                    e = aw_q.pop_front();
                    chk("awaddr", m_awaddr, e.a);
                    chk("awlen", 32'(m_awlen), 32'(e.l));
                end
                wr_addr = m_awaddr; wr_left = int'(m_awlen) + 1;
                open = 1; aw_cnt = rnd(); w_cnt = rnd();
            end
            if (m_wvalid && m_wready) begin
                if (w_q.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
                else begin
                    ew = w_q.pop_front();
                    chk("wdata", m_wdata, ew);
                end
                chk("wlast", 32'(m_wlast), 32'(wr_left == 1));
                dmem[wr_addr] = m_wdata;
                wr_addr += 4; wr_left--; w_cnt = rnd();
                if (wr_left <= 0) begin b_pend = 1; b_gap = rnd(); end
            end
            if (m_bvalid && m_bready) begin b_pend = 0; open = 0; end
        end
        @(posedge aclk); #1;
        if (!aresetn) begin
            rd_left = 0; wr_left = 0; b_pend = 0; open = 0;
            ar_st_p = 0; aw_st_p = 0; w_st_p = 0;
            m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0; m_rlast = 0;
        end else begin
            if (m_arvalid && ar_cnt > 0) ar_cnt--;
            if (m_awvalid && aw_cnt > 0) aw_cnt--;
            if (m_wvalid && w_cnt > 0) w_cnt--;
            m_arready = (ar_cnt == 0);
            m_awready = (aw_cnt == 0);
            m_wready  = (w_cnt == 0);
            m_rvalid = 0;
            if (rd_left > 0) begin
                if (r_gap > 0) r_gap--;
                else begin
                    m_rvalid = 1;
                    m_rdata  = srcw(rd_addr);
                    m_rlast  = (rd_left == 1);
                    m_rresp  = (rd_beat == err_beat_g) ? 2'b10 : 2'b00;
                end
            end
            m_bvalid = 0; m_bresp = 2'b00;
            if (b_pend) begin
                if (b_gap > 0) b_gap--;
                else m_bvalid = 1;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        reg_addr = a; reg_wdata = d; reg_wen = 1'b1;
        @(posedge aclk); #1;
        reg_wen = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        reg_addr = a; #1; d = reg_rdata;
    endtask

    // Reference burst split, pushed to the scoreboard when a transfer starts.
    task automatic push_exp(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int eb);
        logic [31:0] s, d; int rem, b, sr, dr;
        s = src; d = dst; rem = len;
        while (rem > 0) begin
            b  = (rem > MB) ? MB : rem;
            sr = (4096 - int'(s[11:0])) / 4;
            dr = (4096 - int'(d[11:0])) / 4;
            if (b > sr) b = sr;
            if (b > dr) b = dr;
            ar_q.push_back('{s, 8'(b - 1)});
            if (eb >= 0 && eb < b) break;
            aw_q.push_back('{d, 8'(b - 1)});
            for (int k = 0; k < b; k++) w_q.push_back(srcw(s + 32'(4 * k)));
            s += 32'(4 * b); d += 32'(4 * b); rem -= b;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] r; int waited, mism;
        stall_en = v.stall; err_beat_g = v.err_beat;
        n_ar = 0; n_aw = 0; viol = 0;
        wr(4'h0, v.src); wr(4'h4, v.dst); wr(4'h8, 32'(v.len));
        push_exp(v.src, v.dst, v.len, v.err_beat);
        wr(4'hC, 32'h3);
        if (v.len > 0) begin
            rd(4'hC, r);
            chk($sformatf("v%0d_busy", idx), r, 32'h1);
        end
        if (v.poke != 0) begin
            repeat (3) @(posedge aclk); #1;
            wr(4'h0, 32'hDEAD0000); wr(4'h8, 32'd5); wr(4'hC, 32'h1);
        end
        waited = 0;
        while (!irq && waited < 4000) begin @(posedge aclk); #1; waited++; end
        chk($sformatf("v%0d_irq", idx), 32'(irq), 32'd1);
        if (v.len == 0) chk("len0_latency", 32'(waited), 32'd0);
        rd(4'hC, r);
        chk($sformatf("v%0d_status", idx), r, v.exp_status);
        chk($sformatf("v%0d_nar", idx), 32'(n_ar), 32'(v.exp_ar));
        chk($sformatf("v%0d_naw", idx), 32'(n_aw), 32'(v.exp_aw));
        chk($sformatf("v%0d_protocol", idx), 32'(viol), 32'd0);
        chk($sformatf("v%0d_sb_left", idx), 32'(ar_q.size() + aw_q.size() + w_q.size()), 32'd0);
        if (v.poke != 0) begin
            rd(4'h0, r); chk("busy_src_write", r, v.src);
            rd(4'h8, r); chk("busy_len_write", r, 32'(v.len));
        end
        if (v.exp_status == 32'h2) begin
            mism = 0;
            for (int i = 0; i < v.len; i++) begin
                if (!dmem.exists(v.dst + 32'(4 * i)) ||
                    dmem[v.dst + 32'(4 * i)] !== srcw(v.src + 32'(4 * i))) mism++;
            end
            chk($sformatf("v%0d_image", idx), 32'(mism), 32'd0);
        end
        wr(4'hC, 32'h2);
        chk($sformatf("v%0d_irq_clear", idx), 32'(irq), 32'd0);
        ar_q.delete(); aw_q.delete(); w_q.delete();
    endtask

    initial begin
        logic [31:0] r; int w;
        vecs[0] = '{32'h1000, 32'h2000,  4, 0, -1, 0, 32'h2, 1, 1};
        vecs[1] = '{32'h0000, 32'h8000, 40, 0, -1, 1, 32'h2, 3, 3};
        vecs[2] = '{32'h0FF8, 32'h3000,  6, 0, -1, 0, 32'h2, 2, 2};
        vecs[3] = '{32'h5000, 32'h6000,  4, 0,  2, 0, 32'h4, 1, 0};
        vecs[4] = '{32'h7004, 32'h9F00, 33, 1, -1, 0, 32'h2, 3, 3};
        vecs[5] = '{32'h0000, 32'h0000,  0, 0, -1, 0, 32'h2, 0, 0};

        repeat (3) @(posedge aclk); #1;
        chk("rst_valids", {27'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(4'(4 * a), r);
            chk($sformatf("rst_reg%0d", a), r, 32'd0);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Low address bits are forced to zero; LEN keeps 20 bits.
        wr(4'h0, 32'h1234_5677); rd(4'h0, r); chk("src_align", r, 32'h1234_5674);
        wr(4'h8, 32'hFFFF_FFFF); rd(4'h8, r); chk("len_mask", r, 32'h000F_FFFF);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset in the middle of a write burst.
        stall_en = 0; err_beat_g = -1;
        wr(4'h0, 32'h1000); wr(4'h4, 32'h2000); wr(4'h8, 32'd16);
        push_exp(32'h1000, 32'h2000, 16, -1);
        wr(4'hC, 32'h1);
        w = 0;
        while (!m_wvalid && w < 2000) begin @(posedge aclk); #1; w++; end
        chk("reach_w_phase", 32'(m_wvalid), 32'd1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk("midw_rst_valids", {27'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'd0);
        chk("midw_rst_irq", 32'(irq), 32'd0);
        rd(4'hC, r); chk("midw_rst_status", r, 32'd0);
        rd(4'h0, r); chk("midw_rst_src", r, 32'd0);
        ar_q.delete(); aw_q.delete(); w_q.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_copy_dma.md
Name: axi_copy_dma

Overview:
- Memory-to-memory copy engine. Fills the second slave port of the memory mux, the DMA master slot that is currently tied off.
- Software programs source, destination and word count through a small register port.
- The engine moves data as alternating AXI4 INCR read bursts and write bursts through an internal line buffer.
- Completion and errors are reported by status bits and a level interrupt routed to the interrupt controller.

Parameters:
ID_W, 4, AXI ID width, matching the mux slave-port ID width
MAX_BURST, 16, maximum beats per burst and line-buffer depth (power of two, 2..256)
DMA_ID, 0, constant value driven on m_arid and m_awid

Ports:
aclk  input  1  clock; all logic is on this single clock
aresetn  input  1  synchronous active-low reset
reg_wen  input  1  register write strobe, one cycle per write
reg_addr  input  4  word register select: 0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL/STATUS
reg_wdata  input  32  register write data
reg_rdata  output  32  combinational readback of the register at reg_addr
irq  output  1  level interrupt = status.done OR status.err
m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid  output  ID_W,32,8,3,2,1  AR channel
m_arready  input  1  AR ready
m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  input  ID_W,32,2,1,1  R channel
m_rready  output  1  R ready
m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid  output  ID_W,32,8,3,2,1  AW channel
m_awready  input  1  AW ready
m_wdata, m_wstrb, m_wlast, m_wvalid  output  32,4,1,1  W channel
m_wready  input  1  W ready
m_bid, m_bresp, m_bvalid  input  ID_W,2,1  B channel
m_bready  output  1  B ready

Behaviour:
- Reset: all valid/ready outputs 0; irq 0; SRC, DST, LEN 0; busy, done and err 0; FSM in IDLE. Reset mid-transfer abandons it immediately; no bus completion is attempted.
- Register writes:
  - SRC and DST bits [1:0] are forced to 0.
  - LEN counts 32-bit words, 0..2^20-1; upper bits are ignored.
  - Writes to SRC, DST or LEN while busy are ignored.
- CTRL write:
  - bit0 = start; ignored while busy.
  - bit1 = clear; clears done and err, and is accepted at any time.
  - Start and clear in the same write: clear first, then start.
- STATUS read: {29'b0, err, done, busy}.
- Start with LEN=0: done is set on the next cycle; busy never asserts.
- Burst size: beats = min(remaining, MAX_BURST, (4096 - cur_src[11:0])/4, (4096 - cur_dst[11:0])/4). No burst crosses a 4 KB boundary on either side.
- Fixed encodings: arlen/awlen = beats-1; size = 3'b010; burst = INCR; wstrb = 4'hF.
- FSM states and transitions:
  - IDLE -> AR on accepted start. Latch cur_src, cur_dst and remaining; set busy.
  - AR: arvalid held until arready; address and length stable while valid. -> R.
  - R: rready=1. Each beat is stored in buffer[idx]. Any rresp != 0 sets a sticky local error flag. rlast -> AW if no error, else ERR.
  - AW: awvalid held until arready-equivalent awready. -> W.
  - W: beat k drives buffer[k]; wlast on beat beats-1; advance on wvalid&&wready. wvalid drops the cycle after the last handshake. -> B.
  - B: bready=1. On bvalid: bresp != 0 -> ERR. Otherwise advance cur_src and cur_dst by beats*4 and remaining by -beats; remaining==0 -> DONE, else AR.
  - DONE: set done, clear busy -> IDLE (one cycle).
  - ERR: set err, clear busy -> IDLE. The remainder of the transfer is skipped.
- Error-burst fate: a read burst that returned an error is still fully drained (until rlast) but is never written.
- Ordering: exactly one outstanding transaction at any time; reads and writes never overlap.
- rid and bid are ignored.
- irq rises the cycle after done or err sets, and falls the cycle after clear.

Test Plan:
- SRC=0x1000, DST=0x2000, LEN=4, slave with zero wait states -> one AR (len=3), then one AW (len=3) carrying 4 beats equal to the source data; wlast on beat 3; done=1, irq=1; STATUS reads 0x2.
- LEN=40, MAX_BURST=16, aligned addresses -> bursts of 16, 16, 8 on both AR and AW; final cur_dst = DST+160; done set once.
- SRC=0x0FF8, DST=0x3000, LEN=6 -> AR bursts len=1 at 0x0FF8 and len=3 at 0x1000; AW bursts len=1 at 0x3000 and len=3 at 0x3008.
- rresp=2'b10 on beat 2 of 4 -> all 4 beats accepted, no AW issued, err=1, busy=0; clear write -> irq falls the next cycle.
- Random arready/awready/wready/rvalid/bvalid stalls of 0-5 cycles, LEN=33 -> destination image equals source; address, length and data stable while valid is low-ready; AR and AW never outstanding together.
- Start written while busy and LEN=0 start -> second start has no effect; zero-length start sets done with no AXI activity. Reset asserted mid-W -> all outputs return to 0 on the next edge.
